fifo_stream_reader: RTL and testbench

// - Read-side companion to the team's synchronous push/pop FIFO.
// - Drains the FIFO through its pop port and presents the words as a valid/ready stream.
// - Holds words in a 2-entry skid buffer, so i_ready never reaches o_fifo_pop combinationally.
// - Tags every BURST_LEN-th accepted beat with o_last.
// - Supports a flush that discards buffered and queued data.

---
 rtl/fifo_stream_reader_if.sv | 13 +
 rtl/fifo_stream_reader.sv | 173 +++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying words drained from the FIFO.
// The master drives valid/data/last and the slave drives ready.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a push/pop FIFO into a valid/ready stream through a 2-entry skid buffer,
// tagging every BURST_LEN-th accepted beat as last and supporting a discard flush.
module fifo_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = $clog2(BURST_LEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic                 i_fifo_empty,
    input  logic [WIDTH-1:0]     i_fifo_rdata,
    output logic                 o_fifo_pop,
    output logic [CNT_W-1:0]     o_beat_cnt,
    output logic                 o_flushing,
    fifo_stream_reader_if.master strm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       occ_r;
    logic [1:0]       occ_s;
    logic [WIDTH-1:0] ent0_r;
    logic [WIDTH-1:0] ent1_r;
    logic [WIDTH-1:0] ent0_s;
    logic [WIDTH-1:0] ent1_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             valid_r;
    logic             last_r;
    logic             flushing_r;
    logic             pop_s;
    logic             push_s;
    logic             accept_s;
    logic             flush_go_s;

    // Pop request: RUN only tops up the skid buffer, FLUSH drains whatever is queued
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_RUN:   pop_s = !i_fifo_empty && (occ_r != 2'd2);
            ST_FLUSH: pop_s = !i_fifo_empty;
            default:  pop_s = 1'b0;
        endcase
    end

    assign push_s     = pop_s && (state_r == ST_RUN);
    assign accept_s   = valid_r && strm.ready;
    assign flush_go_s = i_flush && (state_r != ST_FLUSH);

    // Next-state logic; a flush request outranks the enable
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_go_s) begin
                    state_s = ST_FLUSH;
                end else if (i_enable) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush_go_s) begin
                    state_s = ST_FLUSH;
                end else if (!i_enable) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // FLUSH pops every non-empty cycle, so an empty FIFO means no pop
                if (i_fifo_empty) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Skid buffer and beat counter: entry 0 is always the presented head
    always_comb begin
        occ_s  = occ_r;
        ent0_s = ent0_r;
        ent1_s = ent1_r;
        cnt_s  = cnt_r;
        if (flush_go_s) begin
            occ_s = 2'd0;
            cnt_s = {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                cnt_s = (cnt_r == CNT_MAX) ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
            end else begin
                cnt_s = cnt_r;
            end
            case ({accept_s, push_s})
                2'b01: begin
                    if (occ_r == 2'd0) begin
                        ent0_s = i_fifo_rdata;
                    end else begin
                        ent1_s = i_fifo_rdata;
                    end
                    occ_s = occ_r + 2'd1;
                end
                2'b10: begin
                    ent0_s = ent1_r;
                    occ_s  = occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        ent0_s = i_fifo_rdata;
                    end else begin
                        ent0_s = ent1_r;
                        ent1_s = i_fifo_rdata;
                    end
                    occ_s = occ_r;
                end
                default: occ_s = occ_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers; stream flags are registered from their next-state values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r      <= 2'd0;
            ent0_r     <= {WIDTH{1'b0}};
            ent1_r     <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            flushing_r <= 1'b0;
        end else begin
            occ_r      <= occ_s;
            ent0_r     <= ent0_s;
            ent1_r     <= ent1_s;
            cnt_r      <= cnt_s;
            valid_r    <= (occ_s != 2'd0);
            last_r     <= (occ_s != 2'd0) && (cnt_s == CNT_MAX);
            flushing_r <= (state_s == ST_FLUSH);
        end
    end

    assign o_fifo_pop = pop_s;
    assign o_beat_cnt = cnt_r;
    assign o_flushing = flushing_r;
    assign strm.valid = valid_r;
    assign strm.data  = ent0_r;
    assign strm.last  = last_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader against a queue-based model;
// a second instance with BURST_LEN=1 runs on the same stimulus.
module tb_fifo_stream_reader;
    localparam int W        = 32;
    localparam int BL       = 4;
    localparam int CW       = $clog2(BL) + 1;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_FLUSH = 2;

    logic          clk          = 1'b0;
    logic          rst          = 1'b0;
    logic          i_enable     = 1'b0;
    logic          i_flush      = 1'b0;
    logic          i_fifo_empty = 1'b1;
    logic [W-1:0]  i_fifo_rdata = '0;
    logic          o_fifo_pop;
    logic          o_flushing;
    logic [CW-1:0] o_beat_cnt;
    logic          pop1;
    logic          flushing1;
    logic [0:0]    cnt1;

    fifo_stream_reader_if #(.WIDTH(W)) s_if ();
    fifo_stream_reader_if #(.WIDTH(W)) s1_if ();

    always #5 clk = ~clk;
    assign s1_if.ready = s_if.ready;

    fifo_stream_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_flush(i_flush),
        .i_fifo_empty(i_fifo_empty), .i_fifo_rdata(i_fifo_rdata),
        .o_fifo_pop(o_fifo_pop), .o_beat_cnt(o_beat_cnt), .o_flushing(o_flushing),
        .strm(s_if)
    );

    fifo_stream_reader #(.WIDTH(W), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_flush(i_flush),
        .i_fifo_empty(i_fifo_empty), .i_fifo_rdata(i_fifo_rdata),
        .o_fifo_pop(pop1), .o_beat_cnt(cnt1), .o_flushing(flushing1),
        .strm(s1_if)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           m_state  = ST_IDLE;
    int           m_cnt    = 0;
    logic [W-1:0] m_q[$];
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_out[$];
    logic [W-1:0] out_q[$];
    int           last_beats[$];
    int           n_acc  = 0;
    int           n_pop  = 0;
    bit           chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit m_pop();
        if (m_state == ST_RUN)   return !i_fifo_empty && (m_q.size() < 2);
        if (m_state == ST_FLUSH) return !i_fifo_empty;
        return 1'b0;
    endfunction

    task automatic drive_fifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_words(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
        drive_fifo();
    endtask

    // Per-cycle compare against the model, plus a record of delivered beats
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("pop", o_fifo_pop, m_pop());
            if (i_fifo_empty) chk("pop_on_empty", o_fifo_pop, 1'b0);
            chk("valid", s_if.valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("data", s_if.data, m_q[0]);
            chk("last", s_if.last, (m_q.size() != 0) && (m_cnt == BL - 1));
            chk("beat_cnt", o_beat_cnt, m_cnt);
            chk("flushing", o_flushing, m_state == ST_FLUSH);
            chk("bl1_pop", pop1, m_pop());
            chk("bl1_valid", s1_if.valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("bl1_data", s1_if.data, m_q[0]);
            chk("bl1_last", s1_if.last, m_q.size() != 0);
            chk("bl1_cnt", cnt1, 1'b0);
            if (s_if.valid && s_if.ready) begin
                out_q.push_back(s_if.data);
                if (s_if.last) last_beats.push_back(n_acc);
                n_acc++;
            end
        end
    end

    // One clock edge: advance the model with the inputs held across that edge
    task automatic cycle();
        bit           p;
        bit           acc;
        logic [W-1:0] w;
        @(posedge clk);
        p   = m_pop();
        acc = (m_q.size() != 0) && s_if.ready;
        w   = i_fifo_rdata;
        if (p) begin
            void'(fifo_q.pop_front());
            n_pop++;
        end
        if (m_state != ST_FLUSH && i_flush) begin
            m_state = ST_FLUSH;
            m_q.delete();
            m_cnt = 0;
        end else begin
            if (acc) begin
                void'(m_q.pop_front());
                m_cnt = (m_cnt == BL - 1) ? 0 : m_cnt + 1;
            end
            if (m_state == ST_RUN && p) m_q.push_back(w);
            case (m_state)
                ST_IDLE: if (i_enable) m_state = ST_RUN;
                ST_RUN:  if (!i_enable) m_state = ST_IDLE;
                default: if (i_fifo_empty) m_state = ST_IDLE;
            endcase
        end
        #1;
        drive_fifo();
    endtask

    task automatic hard_reset();
        rst        = 1'b1;
        i_enable   = 1'b0;
        i_flush    = 1'b0;
        s_if.ready = 1'b0;
        m_state    = ST_IDLE;
        m_q.delete();
        m_cnt = 0;
        fifo_q.delete();
        drive_fifo();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
        last_beats.delete();
        n_acc = 0;
        n_pop = 0;
    endtask

    initial begin
        int           fl;
        int           pushed;
        int           cyc;
        logic [W-1:0] w;
        s_if.ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", s_if.valid, 1'b0);
        chk("rst_data", s_if.data, 32'h0);
        chk("rst_last", s_if.last, 1'b0);
        chk("rst_cnt", o_beat_cnt, 3'd0);
        chk("rst_flushing", o_flushing, 1'b0);
        chk("rst_pop", o_fifo_pop, 1'b0);
        hard_reset();
        chk_en = 1'b1;

        // Burst of 8 with a free-running consumer
        push_words(8, 32'h0000_1000);
        s_if.ready = 1'b1;
        i_enable   = 1'b1;
        cycle();
        cycle();
        chk("t1_valid_rise", s_if.valid, 1'b1);
        chk("t1_first_word", s_if.data, 32'h0000_1000);
        repeat (8) cycle();
        chk("t1_beats", n_acc, 8);
        chk("t1_last_count", last_beats.size(), 2);
        if (last_beats.size() == 2) begin
            chk("t1_last_a", last_beats[0], 3);
            chk("t1_last_b", last_beats[1], 7);
        end
        for (int i = 0; i < out_q.size(); i++) chk("t1_order", out_q[i], 32'h0000_1000 + i);
        chk("t1_cnt_wrap", o_beat_cnt, 3'd0);
        chk("t1_valid_end", s_if.valid, 1'b0);

        // Backpressure with 5 words queued
        hard_reset();
        push_words(5, 32'h0000_2000);
        i_enable = 1'b1;
        repeat (6) cycle();
        chk("t2_pops", n_pop, 2);
        chk("t2_hold", s_if.data, 32'h0000_2000);
        chk("t2_valid", s_if.valid, 1'b1);
        chk("t2_fifo_left", fifo_q.size(), 3);
        s_if.ready = 1'b1;
        repeat (5) cycle();
        chk("t2_beats", n_acc, 5);
        for (int i = 0; i < out_q.size(); i++) chk("t2_order", out_q[i], 32'h0000_2000 + i);
        chk("t2_valid_end", s_if.valid, 1'b0);

        // Random consumer and producer, 1000 words
        hard_reset();
        exp_out.delete();
        i_enable = 1'b1;
        pushed   = 0;
        cyc      = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            s_if.ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
                w = $urandom;
                fifo_q.push_back(w);
                exp_out.push_back(w);
                pushed++;
                drive_fifo();
            end
            cycle();
            cyc++;
        end
        chk("t3_timeout", n_acc >= 1000, 1'b1);
        chk("t3_count", out_q.size(), 1000);
        for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) chk("t3_order", out_q[i], exp_out[i]);

        // Flush with a full skid buffer and 6 words left in the FIFO
        hard_reset();
        push_words(8, 32'h0000_4000);
        i_enable = 1'b1;
        repeat (3) cycle();
        chk("t4_fifo_before", fifo_q.size(), 6);
        chk("t4_valid_before", s_if.valid, 1'b1);
        i_flush = 1'b1;
        cycle();
        i_flush    = 1'b0;
        s_if.ready = 1'b1;
        chk("t4_valid_drop", s_if.valid, 1'b0);
        chk("t4_flushing", o_flushing, 1'b1);
        chk("t4_cnt", o_beat_cnt, 3'd0);
        n_pop = 0;
        fl    = 0;
        while (o_flushing && fl < 30) begin
            cycle();
            fl++;
        end
        chk("t4_flush_cycles", fl, 7);
        chk("t4_pops", n_pop, 6);
        chk("t4_fifo_empty", fifo_q.size(), 0);
        chk("t4_no_beats", n_acc, 0);

        // Disable with one word buffered
        hard_reset();
        push_words(4, 32'h0000_5000);
        i_enable = 1'b1;
        cycle();
        i_enable = 1'b0;
        cycle();
        chk("t5_pops", n_pop, 1);
        chk("t5_valid", s_if.valid, 1'b1);
        s_if.ready = 1'b1;
        repeat (5) cycle();
        chk("t5_beats", n_acc, 1);
        if (out_q.size() != 0) chk("t5_word", out_q[0], 32'h0000_5000);
        chk("t5_no_more_pops", n_pop, 1);
        chk("t5_fifo_left", fifo_q.size(), 3);

        // Asynchronous reset mid-burst
        hard_reset();
        push_words(10, 32'h0000_6000);
        i_enable = 1'b1;
        cycle();
        cycle();
        s_if.ready = 1'b1;
        cycle();
        cycle();
        s_if.ready = 1'b0;
        cycle();
        chk("t6_cnt_before", o_beat_cnt, 3'd2);
        chk("t6_valid_before", s_if.valid, 1'b1);
        #2 rst = 1'b1;
        m_state = ST_IDLE;
        m_q.delete();
        m_cnt = 0;
        #1;
        chk("t6_valid", s_if.valid, 1'b0);
        chk("t6_data", s_if.data, 32'h0);
        chk("t6_last", s_if.last, 1'b0);
        chk("t6_cnt", o_beat_cnt, 3'd0);
        chk("t6_flushing", o_flushing, 1'b0);
        chk("t6_pop", o_fifo_pop, 1'b0);
        i_enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        cycle();
        chk("t6_idle_pop", o_fifo_pop, 1'b0);
        chk("t6_idle_cnt", o_beat_cnt, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
